// File: rtl/wsb_pkg.sv
// Shared types and constants for the multi-lane weight stream buffer.
// Optional build macro WSB_SKEW_EN adds the per-lane diagonal output skew.
package wsb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } wsb_state_e;

    localparam int WSB_DW        = 8;
    localparam int WSB_NUM_LANES = 4;
    localparam int WSB_DEPTH     = 32;
    localparam int WSB_AW        = 5;
    localparam int WSB_LANE_W    = WSB_DW;

    // Low bit of a lane's slice inside a packed row word.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/wsb_lane_delay.sv
// Parametrised shift register used to skew one lane (data plus valid bit).
// A STAGES value of zero degenerates to a plain wire.
module wsb_lane_delay #(
    parameter int W      = 9,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] sr_reg [STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < STAGES; k++) begin
                        sr_reg[k] <= '0;
                    end
                end else begin
                    sr_reg[0] <= din;
                    for (int k = 1; k < STAGES; k++) begin
                        sr_reg[k] <= sr_reg[k-1];
                    end
                end
            end

            assign dout = sr_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/weight_stream_buffer.sv
// Multi-lane writable weight buffer that streams a contiguous run of rows to the PE array.
// Define WSB_SKEW_EN to delay lane i by i extra cycles for diagonal systolic feeding.
module weight_stream_buffer
    import wsb_pkg::*;
#(
    parameter int DW        = WSB_DW,
    parameter int NUM_LANES = WSB_NUM_LANES,
    parameter int DEPTH     = WSB_DEPTH,
    parameter int AW        = WSB_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AW-1:0]           wr_addr,
    input  logic [NUM_LANES*DW-1:0] wr_data,
    input  logic                    rd_start,
    input  logic [AW-1:0]           rd_base,
    input  logic [AW-1:0]           rd_len,
    output logic                    busy,
    output logic [NUM_LANES-1:0]    dout_valid,
    output logic [NUM_LANES*DW-1:0] dout,
    output logic                    done
);

`ifdef WSB_SKEW_EN
    localparam int DRAIN_CYCLES = (NUM_LANES > 1) ? NUM_LANES - 1 : 1;
`else
    localparam int DRAIN_CYCLES = 1;
`endif
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    wsb_state_e state_reg, state_next;
    logic [AW-1:0]  base_reg, base_next;
    logic [AW-1:0]  len_reg, len_next;
    logic [AW-1:0]  cnt_reg, cnt_next;
    logic [DCW-1:0] drain_cnt_reg, drain_cnt_next;
    logic           busy_reg, busy_next;
    logic           wr_ready_reg;
    logic           issue, issue_last, start, wr_fire;
    logic [AW-1:0]  rd_addr;

    logic [NUM_LANES*DW-1:0] mem [DEPTH];
    logic [NUM_LANES*DW-1:0] rd_data_reg;
    logic                    rd_valid_reg, rd_last_reg;
    logic [NUM_LANES*DW-1:0] stage_data_reg;
    logic                    stage_valid_reg, stage_last_reg;

    // busy_reg spans the whole stream including skew tail, so it gates both ports.
    assign start     = rd_start && !busy_reg && (state_reg == ST_IDLE);
    assign wr_fire   = wr_valid && wr_ready_reg;
    assign rd_addr   = base_reg + cnt_reg;
    assign busy_next = start ? 1'b1 : (done ? 1'b0 : busy_reg);
    assign busy      = busy_reg;
    assign wr_ready  = wr_ready_reg;

    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        issue          = 1'b0;
        issue_last     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    base_next  = rd_base;
                    len_next   = rd_len;
                    cnt_next   = '0;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                issue = 1'b1;
                if (cnt_reg == len_reg) begin
                    issue_last     = 1'b1;
                    drain_cnt_next = '0;
                    state_next     = ST_DRAIN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DCW'(DRAIN_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            wr_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            busy_reg      <= busy_next;
            wr_ready_reg  <= !busy_next;
        end
    end

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg    <= 1'b0;
            rd_last_reg     <= 1'b0;
            stage_valid_reg <= 1'b0;
            stage_last_reg  <= 1'b0;
            stage_data_reg  <= '0;
        end else begin
            rd_valid_reg    <= issue;
            rd_last_reg     <= issue_last;
            stage_valid_reg <= rd_valid_reg;
            stage_last_reg  <= rd_last_reg;
            stage_data_reg  <= rd_valid_reg ? rd_data_reg : '0;
        end
    end

`ifdef WSB_SKEW_EN
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DW:0] lane_in, lane_out;
            assign lane_in = {stage_valid_reg, stage_data_reg[lane_lsb(gi, DW) +: DW]};
            wsb_lane_delay #(
                .W      (DW + 1),
                .STAGES (gi)
            ) u_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (lane_in),
                .dout  (lane_out)
            );
            assign dout_valid[gi]                = lane_out[DW];
            assign dout[lane_lsb(gi, DW) +: DW]  = lane_out[DW-1:0];
        end
    endgenerate

    // done follows the last row out of the most-delayed lane.
    wsb_lane_delay #(
        .W      (1),
        .STAGES (NUM_LANES - 1)
    ) u_done_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (stage_last_reg),
        .dout  (done)
    );
`else
    assign dout       = stage_data_reg;
    assign dout_valid = {NUM_LANES{stage_valid_reg}};
    assign done       = stage_last_reg;
`endif

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed self-checking bench for weight_stream_buffer; expectations follow WSB_SKEW_EN.
module tb_weight_stream_buffer;

    localparam int DW    = 8;
    localparam int NL    = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef WSB_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [NL*DW-1:0]  wr_data;
    logic              rd_start;
    logic [AW-1:0]     rd_base;
    logic [AW-1:0]     rd_len;
    logic              busy;
    logic [NL-1:0]     dout_valid;
    logic [NL*DW-1:0]  dout;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_mem [DEPTH][NL];

    weight_stream_buffer #(
        .DW        (DW),
        .NUM_LANES (NL),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_start   (rd_start),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout       (dout),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_stream(input int base, input int len, input int inject_c,
                              input bit same_wr, input logic [NL*DW-1:0] same_data);
        int done_c;
        int r;
        logic [NL*DW-1:0] exp_d;
        logic [NL-1:0]    exp_v;
        done_c = 2 + len + SKEW * (NL - 1);
        @(negedge clk);
        rd_start = 1'b1;
        rd_base  = AW'(base);
        rd_len   = AW'(len);
        if (same_wr) begin
            check("same_cycle_wr_ready", 64'(wr_ready), 64'd1);
            wr_valid = 1'b1;
            wr_addr  = AW'(base);
            wr_data  = same_data;
            for (int i = 0; i < NL; i++) model_mem[base][i] = same_data[i*DW +: DW];
        end
        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge clk);
            rd_start = 1'b0;
            wr_valid = 1'b0;
            exp_d = '0;
            exp_v = '0;
            for (int i = 0; i < NL; i++) begin
                r = c - 2 - SKEW * i;
                if (r >= 0 && r <= len) begin
                    exp_v[i] = 1'b1;
                    exp_d[i*DW +: DW] = model_mem[(base + r) % DEPTH][i];
                end
            end
            $display("stream base=%0d len=%0d c=%0d dout_valid=%b dout=%h done=%b busy=%b",
                     base, len, c, dout_valid, dout, done, busy);
            check("dout_valid", 64'(dout_valid), 64'(exp_v));
            check("dout", 64'(dout), 64'(exp_d));
            check("done", 64'(done), 64'(c == done_c));
            check("busy", 64'(busy), 64'(c <= done_c));
            check("wr_ready", 64'(wr_ready), 64'(c > done_c));
            if (c == inject_c) begin
                rd_start = 1'b1;
                rd_base  = AW'(5);
                rd_len   = AW'(2);
                wr_valid = 1'b1;
                wr_addr  = AW'(2);
                wr_data  = 32'hDEAD_BEEF;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_start = 1'b0;
        rd_base  = '0;
        rd_len   = '0;

        repeat (2) @(negedge clk);
        $display("reset: dout_valid=%b dout=%h done=%b busy=%b wr_ready=%b",
                 dout_valid, dout, done, busy, wr_ready);
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_dout_valid", 64'(dout_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_wr_ready", 64'(wr_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_reset", 64'(wr_ready), 64'd1);

        for (int row = 0; row < DEPTH; row++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(row);
            for (int i = 0; i < NL; i++) begin
                model_mem[row][i] = DW'(row * 4 + i);
                wr_data[i*DW +: DW] = DW'(row * 4 + i);
            end
            $display("write addr=%0d data=%h wr_ready=%b", row, wr_data, wr_ready);
            check("write_ready", 64'(wr_ready), 64'd1);
            @(negedge clk);
        end
        wr_valid = 1'b0;

        run_stream(0, 31, -1, 1'b0, '0);
        run_stream(30, 3, -1, 1'b0, '0);
        run_stream(0, 7, 3, 1'b0, '0);
        run_stream(7, 0, -1, 1'b1, {NL{8'h7F}});
        run_stream(12, 0, -1, 1'b0, '0);

        @(negedge clk);
        rd_start = 1'b1;
        rd_base  = AW'(0);
        rd_len   = AW'(15);
        @(negedge clk);
        rd_start = 1'b0;
        repeat (4) @(negedge clk);
        $display("pre-abort: dout_valid=%b dout=%h busy=%b", dout_valid, dout, busy);
        check("mid_stream_valid", 64'(dout_valid), SKEW ? 64'h7 : 64'hF);
        rst_n = 1'b0;
        #1;
        $display("abort: dout_valid=%b dout=%h done=%b busy=%b", dout_valid, dout, done, busy);
        check("abort_dout", 64'(dout), 64'd0);
        check("abort_dout_valid", 64'(dout_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_abort", 64'(wr_ready), 64'd1);
        check("busy_after_abort", 64'(busy), 64'd0);
        run_stream(0, 7, -1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_stream_buffer.md
Name: weight_stream_buffer

Overview:
- Multi-lane, writable on-chip weight buffer: successor to the single-lane, read-only weight ROM.
- Holds NUM_LANES parallel banks of signed weights.
- Loaded over a valid/ready write port; on command, streams a contiguous run of rows to the systolic-array edge, one row per cycle.
- Sits between the weight DMA/loader and the PE array's weight inputs.

Parameters:
- DW, 8, weight width in bits (signed).
- NUM_LANES, 4, banks/lanes; one lane per PE-array row.
- DEPTH, 32, rows per bank; power of two.
- AW, 5, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid&wr_ready
- wr_addr  in  AW  row address
- wr_data  in  NUM_LANES*DW  row data; lane i = bits [i*DW +: DW]
- rd_start  in  1  single-cycle stream command
- rd_base  in  AW  first row
- rd_len  in  AW  rows to stream minus 1 (0 means 1 row)
- busy  out  1  stream in progress (incl. drain)
- dout_valid  out  NUM_LANES  per-lane output valid
- dout  out  NUM_LANES*DW  per-lane weight
- done  out  1  one-cycle pulse with the final valid output

Behaviour:
- Reset is asynchronous. All outputs and the FSM/counters are forced to 0/IDLE. wr_ready resets to 0, then rises in the first IDLE cycle after reset.
- Memory contents are NOT reset. Contents are undefined until written.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - wr_ready=1.
  - rd_start=1 latches rd_base/rd_len and moves to STREAM.
- STREAM:
  - wr_ready=0.
  - Issues one read address per cycle: rd_base, rd_base+1, ... for rd_len+1 rows.
  - Address arithmetic is modulo DEPTH, so base 30 with len 3 reads 30, 31, 0, 1.
  - After the last address, moves to DRAIN.
- DRAIN:
  - Waits until the last row has left every lane pipeline, then returns to IDLE.
- Read latency:
  - rd_start sampled at edge T gives the first dout_valid at edge T+2.
  - Rows then follow on consecutive cycles with no gaps.
- dout is registered. For any lane with dout_valid=0, that lane's dout is 0.
- done pulses in the same cycle as the final asserted dout_valid bit.
- busy=1 from the cycle after rd_start is sampled through the cycle done is high.
- Writes:
  - Accepted only in IDLE; all lanes of the row are written on the same edge.
  - Write-after-read hazards are not possible because wr_ready=0 while busy.
- rd_start while busy is ignored; the current stream is unaffected.
- rd_start and an accepted write in the same IDLE cycle: the write completes first. The stream starts next cycle and sees the new data.
- Reset asserted mid-stream: the stream is aborted immediately, and done does not pulse.

Optional Feature:
- WSB_SKEW_EN defined:
  - Lane i output (data and valid bit) is delayed by an extra i cycles, giving the diagonal feed the systolic array needs.
  - Lane 0 latency stays 2.
  - DRAIN lasts NUM_LANES-1 cycles.
  - done aligns with the last row on lane NUM_LANES-1.
- Undefined:
  - No skew; all dout_valid bits are identical.
  - DRAIN lasts 1 cycle.

Decomposition:
- Shared package wsb_pkg holds:
  - FSM state enum (IDLE/STREAM/DRAIN);
  - lane-slice helper constant for DW;
  - a default-width localparam set.
- One natural sub-module, wsb_lane_delay: a parametrised shift register (depth i, DW+1 bits) instantiated per lane under WSB_SKEW_EN.

Test Plan:
- Write rows 0..31 with lane i = row*4+i, then stream base 0, len 31 → 32 consecutive rows. dout_valid first rises 2 cycles after rd_start; done occurs with row 31.
- Wrap: stream base 30, len 3 → rows 30, 31, 0, 1 in order; busy deasserts the cycle after done.
- rd_start pulsed again mid-stream with base 5 → ignored; output sequence unchanged; wr_valid during busy sees wr_ready=0 and memory unchanged.
- Same-cycle write (addr 7, data 0x7F..) and rd_start base 7, len 0 → streamed row equals the new data; single done.
- Assert rst_n low mid-stream → dout=0, dout_valid=0, busy=0, no done; post-reset stream of previously written rows still correct.
- With WSB_SKEW_EN, NUM_LANES=4, stream len 0 → lane k valid exactly at cycle T+2+k; done at T+5.
